circuito_pwm_multicanal: RTL and testbench

//   Multi-channel servo PWM generator; next generation of the single-channel circuito_pwm.
//   All channels share one period counter. Each channel has its own target width, set

---
 rtl/circuito_pwm_multicanal.sv | 116 +++++++++++
 tb/tb_circuito_pwm_multicanal.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/circuito_pwm_multicanal.sv
// Multi-channel servo PWM generator with a shared period counter, per-channel
// target widths from a linear position map, and an optional per-period slew limit.
module circuito_pwm_multicanal #(
   parameter int unsigned NUM_CANAIS   = 4,
   parameter int unsigned POS_BITS     = 3,
   parameter int unsigned CONF_PERIODO = 1000000,
   parameter int unsigned LARG_MIN     = 50000,
   parameter int unsigned DELTA        = 5556,
   parameter int unsigned LARG_MAX     = 100000,
   parameter int unsigned PASSO        = 0,
   parameter int unsigned POS_INICIAL  = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [3:0]            wr_canal,
   input  logic [POS_BITS-1:0]   wr_posicao,
   output logic [NUM_CANAIS-1:0] pwm,
   output logic [NUM_CANAIS-1:0] em_movimento,
   output logic                  inicio_periodo,
   output logic                  wr_erro
);

   // Widths never exceed LARG_MAX < CONF_PERIODO, so they share the counter width.
   localparam int unsigned CW = (CONF_PERIODO > 2) ? $clog2(CONF_PERIODO) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(CONF_PERIODO - 1);

   // Linear position map, evaluated at 64 bits so large codes cannot wrap before the clamp.
   function automatic logic [CW-1:0] largura_de(input logic [POS_BITS-1:0] p);
      logic [63:0] w;
      w = 64'(LARG_MIN) + 64'(p) * 64'(DELTA);
      if (w > 64'(LARG_MAX)) w = 64'(LARG_MAX);
      return CW'(w);
   endfunction

   // One slew step toward the target; PASSO==0 means jump straight there.
   function automatic logic [CW-1:0] aproxima(input logic [CW-1:0] atual,
                                              input logic [CW-1:0] alvo);
      logic [CW-1:0] dif;
      if (PASSO == 0) return alvo;
      if (alvo > atual) begin
         dif = alvo - atual;
         if (32'(dif) > PASSO) return atual + CW'(PASSO);
         return alvo;
      end
      dif = atual - alvo;
      if (32'(dif) > PASSO) return atual - CW'(PASSO);
      return alvo;
   endfunction

   localparam logic [CW-1:0] LARG_INI = largura_de(POS_BITS'(POS_INICIAL));

   logic [CW-1:0]         contador_q, contador_d;
   logic [CW-1:0]         alvo_q    [NUM_CANAIS];
   logic [CW-1:0]         alvo_d    [NUM_CANAIS];
   logic [CW-1:0]         largura_q [NUM_CANAIS];
   logic [CW-1:0]         largura_d [NUM_CANAIS];
   logic [NUM_CANAIS-1:0] pwm_q, pwm_d;
   logic [NUM_CANAIS-1:0] em_q, em_d;
   logic                  inicio_q, inicio_d;
   logic                  erro_q, erro_d;
   logic                  fim;

   assign fim = (contador_q == ULTIMO);

   // Next-state: counter wrap, writes into targets, width update only at the period boundary.
   always_comb begin
      contador_d = fim ? '0 : contador_q + 1'b1;
      inicio_d   = (contador_q == '0);
      erro_d     = wr_en && (32'(wr_canal) >= NUM_CANAIS);
      pwm_d      = '0;
      em_d       = em_q;
      for (int unsigned i = 0; i < NUM_CANAIS; i++) begin
         alvo_d[i]    = alvo_q[i];
         largura_d[i] = largura_q[i];
         pwm_d[i]     = (contador_q < largura_q[i]);
         // The update reads alvo_q, so a write on the boundary edge waits one period.
         if (fim) begin
            largura_d[i] = aproxima(largura_q[i], alvo_q[i]);
            em_d[i]      = (largura_d[i] != alvo_q[i]);
         end
         if (wr_en && (32'(wr_canal) == i)) alvo_d[i] = largura_de(wr_posicao);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contador_q <= '0;
         pwm_q      <= '0;
         em_q       <= '0;
         inicio_q   <= 1'b0;
         erro_q     <= 1'b0;
         for (int unsigned i = 0; i < NUM_CANAIS; i++) begin
            alvo_q[i]    <= LARG_INI;
            largura_q[i] <= LARG_INI;
         end
      end else begin
         contador_q <= contador_d;
         pwm_q      <= pwm_d;
         em_q       <= em_d;
         inicio_q   <= inicio_d;
         erro_q     <= erro_d;
         for (int unsigned i = 0; i < NUM_CANAIS; i++) begin
            alvo_q[i]    <= alvo_d[i];
            largura_q[i] <= largura_d[i];
         end
      end
   end

   assign pwm            = pwm_q;
   assign em_movimento   = em_q;
   assign inicio_periodo = inicio_q;
   assign wr_erro        = erro_q;

endmodule

// File: tb/tb_circuito_pwm_multicanal.sv
// Bench for circuito_pwm_multicanal: a slewed (PASSO=4) and a direct (PASSO=0)
// instance share stimulus; a period/phase model checks every cycle.
module tb_circuito_pwm_multicanal;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_canal = '0;
   logic [2:0] wr_posicao = '0;
   logic [3:0] pwm_a, em_a, pwm_b, em_b;
   logic       ini_a, erro_a, ini_b, erro_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   circuito_pwm_multicanal #(
      .NUM_CANAIS(4), .POS_BITS(3), .CONF_PERIODO(100), .LARG_MIN(10),
      .DELTA(5), .LARG_MAX(40), .PASSO(4), .POS_INICIAL(0)
   ) u_dut (
      .clock(clk), .reset(reset), .wr_en(wr_en), .wr_canal(wr_canal),
      .wr_posicao(wr_posicao), .pwm(pwm_a), .em_movimento(em_a),
      .inicio_periodo(ini_a), .wr_erro(erro_a)
   );

   circuito_pwm_multicanal #(
      .NUM_CANAIS(4), .POS_BITS(3), .CONF_PERIODO(100), .LARG_MIN(10),
      .DELTA(5), .LARG_MAX(40), .PASSO(0), .POS_INICIAL(0)
   ) u_dut0 (
      .clock(clk), .reset(reset), .wr_en(wr_en), .wr_canal(wr_canal),
      .wr_posicao(wr_posicao), .pwm(pwm_b), .em_movimento(em_b),
      .inicio_periodo(ini_b), .wr_erro(erro_b)
   );

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   function automatic int larg(input int p);
      int w;
      w = 10 + p * 5;
      return (w > 40) ? 40 : w;
   endfunction

   function automatic int passo_para(input int cur, input int tgt, input int passo);
      int d;
      if (passo == 0) return tgt;
      d = tgt - cur;
      if (d > passo) d = passo;
      if (d < -passo) d = -passo;
      return cur + d;
   endfunction

   // Model: edge e after reset release sees phase (e-1)%100; a period's width is fixed.
   int   m_tgt [2][4];
   int   m_w   [2][4];
   logic m_em  [2][4];
   int   passo_m [2] = '{4, 0};
   int   e = 0;

   always @(posedge clk) begin
      logic       en;
      int         can, pos, ph;
      logic [3:0] x_pwm [2];
      logic [3:0] x_em  [2];
      logic       x_ini, x_err;
      en = wr_en; can = int'(wr_canal); pos = int'(wr_posicao);
      x_ini = 1'b0; x_err = 1'b0;
      x_pwm[0] = '0; x_pwm[1] = '0; x_em[0] = '0; x_em[1] = '0;
      if (!reset) begin
         e = 0;
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) begin
               m_tgt[m][i] = 10; m_w[m][i] = 10; m_em[m][i] = 1'b0;
            end
      end else begin
         e++;
         ph = (e - 1) % 100;
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) x_pwm[m][i] = (ph < m_w[m][i]);
         x_ini = (ph == 0);
         x_err = en && (can >= 4);
         if (ph == 99)
            for (int m = 0; m < 2; m++)
               for (int i = 0; i < 4; i++) begin
                  m_w[m][i]  = passo_para(m_w[m][i], m_tgt[m][i], passo_m[m]);
                  m_em[m][i] = (m_w[m][i] != m_tgt[m][i]);
               end
         if (en && can < 4)
            for (int m = 0; m < 2; m++) m_tgt[m][can] = larg(pos);
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) x_em[m][i] = m_em[m][i];
      end
      #1;
      chk("cyc_pwm_a", int'(pwm_a), int'(x_pwm[0]));
      chk("cyc_pwm_b", int'(pwm_b), int'(x_pwm[1]));
      chk("cyc_em_a", int'(em_a), int'(x_em[0]));
      chk("cyc_em_b", int'(em_b), int'(x_em[1]));
      chk("cyc_ini_a", int'(ini_a), int'(x_ini));
      chk("cyc_ini_b", int'(ini_b), int'(x_ini));
      chk("cyc_err_a", int'(erro_a), int'(x_err));
      chk("cyc_err_b", int'(erro_b), int'(x_err));
   end

   int         med_w [2][4];
   logic [3:0] med_em [2];
   int         med_ini;

   task automatic sincroniza();
      int n;
      n = 0;
      while (!ini_a && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!ini_a) begin
         chk("timeout_inicio", 0, 1);
         $display("FAIL timeout waiting for inicio_periodo");
         $fatal(1, "no period start");
      end
   endtask

   // Counts high cycles per channel over one full period starting at inicio_periodo.
   task automatic medir();
      sincroniza();
      med_em[0] = em_a; med_em[1] = em_b; med_ini = 0;
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 4; i++) med_w[m][i] = 0;
      for (int k = 0; k < 100; k++) begin
         for (int i = 0; i < 4; i++) begin
            med_w[0][i] += int'(pwm_a[i]);
            med_w[1][i] += int'(pwm_b[i]);
         end
         med_ini += int'(ini_a);
         if (k < 99) @(negedge clk);
      end
   endtask

   task automatic escreve(input int c, input int p);
      wr_en = 1'b1; wr_canal = 4'(c); wr_posicao = 3'(p);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   int seq_a [4] = '{14, 18, 22, 25};
   int em1_a [4] = '{1, 1, 1, 0};
   int seq_c [9] = '{14, 18, 22, 26, 30, 34, 38, 40, 40};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_pwm_a", int'(pwm_a), 0);
      chk("rst_em_a", int'(em_a), 0);
      chk("rst_ini_a", int'(ini_a), 0);
      chk("rst_erro_a", int'(erro_a), 0);
      chk("rst_pwm_b", int'(pwm_b), 0);
      reset = 1'b1;

      // Free run: every channel 10 cycles high, one period start per period.
      medir();
      for (int i = 0; i < 4; i++) begin
         chk("t1_w_a", med_w[0][i], 10);
         chk("t1_w_b", med_w[1][i], 10);
      end
      chk("t1_ini_count", med_ini, 1);

      // Reset dropped in the middle of a pulse clears pwm immediately.
      @(negedge clk);
      repeat (3) @(negedge clk);
      chk("t1_pre_drop", int'(pwm_a), 15);
      #2 reset = 1'b0;
      #1;
      chk("t1_drop_pwm_a", int'(pwm_a), 0);
      chk("t1_drop_pwm_b", int'(pwm_b), 0);
      @(negedge clk) reset = 1'b1;
      repeat (5) @(negedge clk);

      // Ch1 position 3 ramps 14,18,22,25 in the slewed instance.
      escreve(1, 3);
      repeat (5) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         medir();
         chk("t2_w1_a", med_w[0][1], seq_a[p]);
         chk("t2_em1_a", int'(med_em[0][1]), em1_a[p]);
         chk("t2_w0_a", med_w[0][0], 10);
         chk("t2_w2_a", med_w[0][2], 10);
         chk("t2_w3_a", med_w[0][3], 10);
         chk("t2_w1_b", med_w[1][1], 25);
      end

      // Ch2 position 7 clamps to 40 and holds.
      escreve(2, 7);
      repeat (5) @(negedge clk);
      for (int p = 0; p < 9; p++) begin
         medir();
         chk("t3_w2_a", med_w[0][2], seq_c[p]);
         chk("t3_w2_b", med_w[1][2], 40);
      end
      chk("t3_em2_a", int'(med_em[0][2]), 0);

      // Write to channel 5: single-cycle error pulse, nothing else moves.
      @(negedge clk);
      wr_en = 1'b1; wr_canal = 4'd5; wr_posicao = 3'd7;
      @(posedge clk);
      #1;
      chk("t4_erro_on_a", int'(erro_a), 1);
      chk("t4_erro_on_b", int'(erro_b), 1);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_erro_off_a", int'(erro_a), 0);
      @(negedge clk);
      medir();
      chk("t4_w0_a", med_w[0][0], 10);
      chk("t4_w1_a", med_w[0][1], 25);
      chk("t4_w2_a", med_w[0][2], 40);
      chk("t4_w3_a", med_w[0][3], 10);
      chk("t4_w3_b", med_w[1][3], 10);

      // Write on the contador==99 edge: old target used for this boundary.
      @(negedge clk);
      sincroniza();
      repeat (98) @(negedge clk);
      escreve(0, 1);
      medir();
      chk("t5_first_a", med_w[0][0], 10);
      chk("t5_first_b", med_w[1][0], 10);
      chk("t5_em0_first", int'(med_em[0][0]), 0);
      medir();
      chk("t5_second_a", med_w[0][0], 14);
      chk("t5_second_b", med_w[1][0], 15);
      chk("t5_em0_second", int'(med_em[0][0]), 1);

      // Direct instance jumps to 20 with no movement flag.
      repeat (5) @(negedge clk);
      escreve(3, 2);
      repeat (5) @(negedge clk);
      medir();
      chk("t6_w3_b", med_w[1][3], 20);
      chk("t6_em3_b", int'(med_em[1][3]), 0);
      chk("t6_w3_a", med_w[0][3], 14);
      medir();
      chk("t6_w3_b_hold", med_w[1][3], 20);

      // Random writes, checked by the per-cycle model.
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(1, 20)) @(negedge clk);
         escreve(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      end
      repeat (400) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
